// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: pulls W[0..63] from the schedule generator, runs one
// round per returned word, and folds the working variables into the chaining value.
module sha256_round_engine #(
  parameter int W_LAT = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] h_in,
  output logic         w_go,
  input  logic         w_reg_rdy,
  output logic         w_reg_read,
  output logic [5:0]   w_reg_addr,
  input  logic [31:0]  w_reg_data,
  output logic         busy,
  output logic         done,
  output logic [255:0] digest,
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_STREAM, S_FINAL, S_WAIT} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t           state;
  logic [6:0]       req_cnt;
  logic [6:0]       rnd_cnt;
  logic [5:0]       addr_q;
  logic [W_LAT-1:0] vld_sr;
  logic [31:0]      hv    [8];
  logic [31:0]      wk    [8];
  logic [31:0]      wk_n  [8];
  logic [31:0]      sums  [8];
  logic [31:0]      s0, s1, ch, maj, t1, t2;
  logic             round_en;

  // Read handshake: a word is requested in any STREAM cycle where the generator
  // reports ready; it is never held pending, so a dropped ready simply skips the cycle.
  assign w_reg_read = (state == S_STREAM) && w_reg_rdy && (req_cnt < 7'd64);
  assign w_reg_addr = w_reg_read ? req_cnt[5:0] : addr_q;
  assign round_en   = vld_sr[W_LAT-1] && (state == S_STREAM);
  assign state_dbg  = state;

  always_comb begin
    s0  = {wk[0][1:0], wk[0][31:2]} ^ {wk[0][12:0], wk[0][31:13]} ^ {wk[0][21:0], wk[0][31:22]};
    s1  = {wk[4][5:0], wk[4][31:6]} ^ {wk[4][10:0], wk[4][31:11]} ^ {wk[4][24:0], wk[4][31:25]};
    ch  = (wk[4] & wk[5]) ^ (~wk[4] & wk[6]);
    maj = (wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]);
    t1  = wk[7] + s1 + ch + K_ROM[rnd_cnt[5:0]] + w_reg_data;
    t2  = s0 + maj;
    wk_n[0] = t1 + t2;
    wk_n[1] = wk[0];
    wk_n[2] = wk[1];
    wk_n[3] = wk[2];
    wk_n[4] = wk[3] + t1;
    wk_n[5] = wk[4];
    wk_n[6] = wk[5];
    wk_n[7] = wk[6];
    for (int i = 0; i < 8; i++) sums[i] = hv[i] + wk[i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      w_go    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      digest  <= '0;
      req_cnt <= '0;
      rnd_cnt <= '0;
      addr_q  <= '0;
      vld_sr  <= '0;
      for (int i = 0; i < 8; i++) begin
        hv[i] <= '0;
        wk[i] <= '0;
      end
    end else begin
      done      <= 1'b0;
      vld_sr[0] <= w_reg_read;
      for (int i = 1; i < W_LAT; i++) vld_sr[i] <= vld_sr[i-1];
      if (w_reg_read) begin
        req_cnt <= req_cnt + 7'd1;
        addr_q  <= req_cnt[5:0];
      end
      if (round_en) begin
        wk      <= wk_n;
        rnd_cnt <= rnd_cnt + 7'd1;
      end
      case (state)
        S_IDLE: if (start) begin
          state   <= S_REQ;
          w_go    <= 1'b1;
          busy    <= 1'b1;
          req_cnt <= '0;
          rnd_cnt <= '0;
          for (int i = 0; i < 8; i++) begin
            hv[i] <= h_in[255-32*i -: 32];
            wk[i] <= h_in[255-32*i -: 32];
          end
        end
        S_REQ: if (w_reg_rdy) state <= S_STREAM;
        // Leave on the edge that retires round 63 so FINAL sees the last working set.
        S_STREAM: if (round_en && rnd_cnt == 7'd63) begin
          state <= S_FINAL;
          w_go  <= 1'b0;
        end
        S_FINAL: begin
          for (int i = 0; i < 8; i++) begin
            hv[i]                  <= sums[i];
            digest[255-32*i -: 32] <= sums[i];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: if (!w_reg_rdy) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
